huffman_ctrl: RTL

Job sequencer for the Huffman encode/decode core. It accepts one message from an upstream byte stream and buffers it. It then replays the message into the core's text input, waits for encode completion, and collects the decoded characters. Each decoded character is compared against the buffered original, and one loopback verdict is reported per job. It sits between the system byte source and the `huffman` top, and owns the core's `data_en`/`text` inputs exclusively.

---
 rtl/huffman_pkg.sv | 20 ++
 rtl/huffman_ctrl_buf.sv | 41 ++++
 rtl/huffman_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// huffman_pkg
//   Shared types and widths for the Huffman job sequencer.
//   ctrl_state_e : sequencer FSM states
//   TOTAL_BIT_W  : width of the core's encoded bit count
//   CHAR_W       : width of a decoded character from the core
package huffman_pkg;

  localparam int TOTAL_BIT_W = 11;
  localparam int CHAR_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FEED,
    ST_ENCODE,
    ST_DECODE,
    ST_REPORT
  } ctrl_state_e;

endpackage

// File: rtl/huffman_ctrl_buf.sv
// huffman_ctrl_buf
//   Message buffer: MAX_LEN x BIT_WIDTH register file with one synchronous
//   write port and one asynchronous read port. Contents are never reset.
//   Out-of-range writes are dropped and out-of-range reads return zero.
//   Ports:
//     clk_i      : clock
//     i_wr_en    : write strobe
//     i_wr_addr  : write index
//     i_wr_data  : write data
//     i_rd_addr  : read index
//     o_rd_data  : read data (combinational)
module huffman_ctrl_buf
  import huffman_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int MAX_LEN   = 16,
  parameter int ADDR_W    = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk_i,
  input  logic                 i_wr_en,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [BIT_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic [BIT_WIDTH-1:0] o_rd_data
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(MAX_LEN);

  logic [BIT_WIDTH-1:0] r_mem [MAX_LEN];

  always_ff @(posedge clk_i) begin
    if (i_wr_en && (i_wr_addr < DEPTH_L)) begin
      r_mem[i_wr_addr[IDX_W-1:0]] <= i_wr_data;
    end
  end

  // Read index may legally sit at MAX_LEN once a counter has run off the end.
  assign o_rd_data = (i_rd_addr < DEPTH_L) ? r_mem[i_rd_addr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/huffman_ctrl.sv
// huffman_ctrl
//   Job sequencer for the Huffman encode/decode core. Buffers one message
//   from the upstream byte stream, replays it into the core text input,
//   waits for encode completion, checks every decoded character against the
//   buffered original and reports one loopback verdict per job.
//   Ports:
//     clk_i, rst_i                   : clock, synchronous active-high reset
//     s_valid_i/s_data_i/s_last_i    : upstream character stream
//     s_ready_o                      : upstream accept
//     core_en_o/core_text_o          : core data_en / input_text drive
//     core_done_en_i/core_total_bit_i: encode done and encoded bit count
//     core_char_vld_i/core_char_i    : decoded character strobe and value
//     core_done_de_i                 : decode done
//     busy_o                         : not idle
//     done_o                         : one-cycle job-end pulse
//     pass_o/timeout_o               : job verdict, held until next job
//     len_o/total_bit_o              : accepted length, encoded bit count
module huffman_ctrl
  import huffman_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int MAX_LEN   = 16,
  parameter int TIMEOUT   = 4095,
  localparam int LEN_W    = $clog2(MAX_LEN + 1),
  localparam int WD_W     = $clog2(TIMEOUT + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   s_valid_i,
  input  logic [BIT_WIDTH-1:0]   s_data_i,
  input  logic                   s_last_i,
  output logic                   s_ready_o,
  output logic                   core_en_o,
  output logic [BIT_WIDTH-1:0]   core_text_o,
  input  logic                   core_done_en_i,
  input  logic [TOTAL_BIT_W-1:0] core_total_bit_i,
  input  logic                   core_char_vld_i,
  input  logic [CHAR_W-1:0]      core_char_i,
  input  logic                   core_done_de_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   timeout_o,
  output logic [LEN_W-1:0]       len_o,
  output logic [TOTAL_BIT_W-1:0] total_bit_o
);

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);

  ctrl_state_e            r_state;
  logic [LEN_W-1:0]       r_len, r_rd, r_cmp;
  logic [WD_W-1:0]        r_wd;
  logic                   r_err;
  logic                   r_ready, r_core_en, r_busy, r_done, r_pass, r_timeout;
  logic [BIT_WIDTH-1:0]   r_core_text;
  logic [TOTAL_BIT_W-1:0] r_total_bit;

  logic                   w_accept;
  logic [LEN_W-1:0]       w_wr_addr, w_rd_addr, w_len_inc, w_cmp_nxt;
  logic [BIT_WIDTH-1:0]   w_rd_data;
  logic                   w_err_nxt, w_wd_expired;

  assign w_accept     = s_valid_i && r_ready && !rst_i;
  assign w_wr_addr    = (r_state == ST_IDLE) ? '0 : r_len;
  // FEED walks the buffer with rd, DECODE with cmp.
  assign w_rd_addr    = (r_state == ST_DECODE) ? r_cmp : r_rd;
  assign w_len_inc    = r_len + 1'b1;
  assign w_wd_expired = (r_wd == WD_LIMIT);

  huffman_ctrl_buf #(
    .BIT_WIDTH (BIT_WIDTH),
    .MAX_LEN   (MAX_LEN),
    .ADDR_W    (LEN_W)
  ) u_buf (
    .clk_i     (clk_i),
    .i_wr_en   (w_accept),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (s_data_i),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Compare result including a strobe landing in the same cycle as done_de.
  // cmp stops at len; a surplus strobe only raises err.
  always_comb begin
    w_err_nxt = r_err;
    w_cmp_nxt = r_cmp;
    if (core_char_vld_i) begin
      if (r_cmp >= r_len) begin
        w_err_nxt = 1'b1;
      end else begin
        if (core_char_i != CHAR_W'(w_rd_data)) w_err_nxt = 1'b1;
        w_cmp_nxt = r_cmp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_rd        <= '0;
      r_cmp       <= '0;
      r_wd        <= '0;
      r_err       <= 1'b0;
      r_ready     <= 1'b0;
      r_core_en   <= 1'b0;
      r_core_text <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_total_bit <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_len       <= LEN_W'(1);
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_total_bit <= '0;
            r_busy      <= 1'b1;
            if (s_last_i || (LEN_MAX == LEN_W'(1))) begin
              // Buffer write lands on this edge, so forward the beat directly.
              r_state     <= ST_FEED;
              r_ready     <= 1'b0;
              r_core_en   <= 1'b1;
              r_core_text <= s_data_i;
              r_rd        <= LEN_W'(1);
            end else begin
              r_state <= ST_LOAD;
              r_rd    <= '0;
            end
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_len <= w_len_inc;
            if (s_last_i || (w_len_inc == LEN_MAX)) begin
              r_state     <= ST_FEED;
              r_ready     <= 1'b0;
              r_core_en   <= 1'b1;
              r_core_text <= w_rd_data;
              r_rd        <= LEN_W'(1);
            end
          end
        end
        ST_FEED: begin
          if (r_rd == r_len) begin
            r_state     <= ST_ENCODE;
            r_core_en   <= 1'b0;
            r_core_text <= '0;
            r_wd        <= '0;
          end else begin
            r_core_text <= w_rd_data;
            r_rd        <= r_rd + 1'b1;
          end
        end
        ST_ENCODE: begin
          r_wd <= r_wd + 1'b1;
          if (w_wd_expired) begin
            r_state   <= ST_REPORT;
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
            r_done    <= 1'b1;
          end else if (core_done_en_i) begin
            r_state     <= ST_DECODE;
            r_total_bit <= core_total_bit_i;
            r_cmp       <= '0;
            r_err       <= 1'b0;
          end
        end
        ST_DECODE: begin
          r_wd <= r_wd + 1'b1;
          if (w_wd_expired) begin
            r_state   <= ST_REPORT;
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_cmp <= w_cmp_nxt;
            r_err <= w_err_nxt;
            if (core_done_de_i) begin
              r_state <= ST_REPORT;
              r_pass  <= !w_err_nxt && (w_cmp_nxt == r_len);
              r_done  <= 1'b1;
            end
          end
        end
        ST_REPORT: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign s_ready_o   = r_ready;
  assign core_en_o   = r_core_en;
  assign core_text_o = r_core_text;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign pass_o      = r_pass;
  assign timeout_o   = r_timeout;
  assign len_o       = r_len;
  assign total_bit_o = r_total_bit;

endmodule
